// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W      = 5;
  localparam int unsigned MEM_READ_W      = 3;
  localparam int unsigned DIV_CNT_W       = 8;
  localparam int unsigned DIV_LATENCY_DEF = 32;

  localparam logic [MEM_READ_W-1:0] MEM_NO_LOAD = 3'b000;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_DIV_BUSY = 1'b1
  } state_e;

  // Pipeline register controls produced each cycle
  typedef struct packed {
    logic pc_hold;
    logic if_id_hold;
    logic id_ex_hold;
    logic id_ex_bubble;
    logic ex_mem_bubble;
    logic if_id_flush;
    logic busy;
  } ctrl_t;

endpackage

// File: rtl/stall_perf_counter.sv
// Saturating event counter with enable and synchronous active-low clear.
module stall_perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_clr_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Stops at all-ones rather than wrapping
  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hold/bubble/flush sequencing for the 5-stage pipeline: load-use stall,
// iterative-divide hold and taken-branch flush, plus a stall-cycle counter.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned DIV_LATENCY = DIV_LATENCY_DEF,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [REG_ADDR_W-1:0] ADDR1,
  input  logic [REG_ADDR_W-1:0] ADDR2,
  input  logic [REG_ADDR_W-1:0] ADDR_S3,
  input  logic [MEM_READ_W-1:0] MEM_READ_S3,
  input  logic                  DIV_START_S3,
  input  logic                  BRANCH_TAKEN_S3,
  output logic                  PC_HOLD,
  output logic                  IF_ID_HOLD,
  output logic                  ID_EX_HOLD,
  output logic                  ID_EX_BUBBLE,
  output logic                  EX_MEM_BUBBLE,
  output logic                  IF_ID_FLUSH,
  output logic                  BUSY,
  output logic [CNT_W-1:0]      STALL_CNT
);

  localparam logic [DIV_CNT_W-1:0] DIV_CNT_INIT = DIV_CNT_W'(DIV_LATENCY - 1);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [DIV_CNT_W-1:0] r_cnt;
  logic [DIV_CNT_W-1:0] w_cnt_nxt;
  logic                 w_load_use;
  ctrl_t                w_ctrl;

  // x0 is never a real producer, so it cannot create a load-use hazard
  assign w_load_use = (MEM_READ_S3 != MEM_NO_LOAD) &&
                      (ADDR_S3 != REG_ADDR_W'(0)) &&
                      ((ADDR1 == ADDR_S3) || (ADDR2 == ADDR_S3));

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and Mealy controls; everything is forced low while in reset
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ctrl      = '0;
    if (RESET) begin
      unique case (r_state)
        ST_IDLE: begin
          if (BRANCH_TAKEN_S3) begin
            w_ctrl.if_id_flush  = 1'b1;
            w_ctrl.id_ex_bubble = 1'b1;
          end else if (DIV_START_S3) begin
            w_ctrl.pc_hold       = 1'b1;
            w_ctrl.if_id_hold    = 1'b1;
            w_ctrl.id_ex_hold    = 1'b1;
            w_ctrl.ex_mem_bubble = 1'b1;
            w_state_nxt          = ST_DIV_BUSY;
            w_cnt_nxt            = DIV_CNT_INIT;
          end else if (w_load_use) begin
            w_ctrl.pc_hold      = 1'b1;
            w_ctrl.if_id_hold   = 1'b1;
            w_ctrl.id_ex_bubble = 1'b1;
          end
        end
        ST_DIV_BUSY: begin
          w_ctrl.pc_hold    = 1'b1;
          w_ctrl.if_id_hold = 1'b1;
          w_ctrl.id_ex_hold = 1'b1;
          w_ctrl.busy       = 1'b1;
          // Last busy cycle lets EX/MEM capture the divider result
          w_ctrl.ex_mem_bubble = (r_cnt > DIV_CNT_W'(1));
          if (r_cnt <= DIV_CNT_W'(1)) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - DIV_CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign PC_HOLD       = w_ctrl.pc_hold;
  assign IF_ID_HOLD    = w_ctrl.if_id_hold;
  assign ID_EX_HOLD    = w_ctrl.id_ex_hold;
  assign ID_EX_BUBBLE  = w_ctrl.id_ex_bubble;
  assign EX_MEM_BUBBLE = w_ctrl.ex_mem_bubble;
  assign IF_ID_FLUSH   = w_ctrl.if_id_flush;
  assign BUSY          = w_ctrl.busy;

  stall_perf_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .i_clk   (CLK),
    .i_clr_n (RESET),
    .i_en    (w_ctrl.pc_hold),
    .o_cnt   (STALL_CNT)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (short divide / narrow counter and
// default divide / wide counter) driven in lockstep against a cycle-level model.
module tb_hazard_stall_ctrl;

  logic       CLK;
  logic       RESET;
  logic [4:0] ADDR1, ADDR2, ADDR_S3;
  logic [2:0] MEM_READ_S3;
  logic       DIV_START_S3, BRANCH_TAKEN_S3;

  logic        pc_a, ifh_a, idh_a, idb_a, exb_a, fl_a, busy_a;
  logic [3:0]  st_a;
  logic        pc_b, ifh_b, idh_b, idb_b, exb_b, fl_b, busy_b;
  logic [31:0] st_b;

  int checks = 0;
  int errors = 0;

  int     m_left [2];
  longint m_stall[2];
  int     lat    [2] = '{4, 32};
  longint cap    [2] = '{15, 64'h0000_0000_FFFF_FFFF};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  hazard_stall_ctrl #(.DIV_LATENCY(4), .CNT_W(4)) dut_a (
    .CLK(CLK), .RESET(RESET), .ADDR1(ADDR1), .ADDR2(ADDR2), .ADDR_S3(ADDR_S3),
    .MEM_READ_S3(MEM_READ_S3), .DIV_START_S3(DIV_START_S3), .BRANCH_TAKEN_S3(BRANCH_TAKEN_S3),
    .PC_HOLD(pc_a), .IF_ID_HOLD(ifh_a), .ID_EX_HOLD(idh_a), .ID_EX_BUBBLE(idb_a),
    .EX_MEM_BUBBLE(exb_a), .IF_ID_FLUSH(fl_a), .BUSY(busy_a), .STALL_CNT(st_a));

  hazard_stall_ctrl #(.DIV_LATENCY(32), .CNT_W(32)) dut_b (
    .CLK(CLK), .RESET(RESET), .ADDR1(ADDR1), .ADDR2(ADDR2), .ADDR_S3(ADDR_S3),
    .MEM_READ_S3(MEM_READ_S3), .DIV_START_S3(DIV_START_S3), .BRANCH_TAKEN_S3(BRANCH_TAKEN_S3),
    .PC_HOLD(pc_b), .IF_ID_HOLD(ifh_b), .ID_EX_HOLD(idh_b), .ID_EX_BUBBLE(idb_b),
    .EX_MEM_BUBBLE(exb_b), .IF_ID_FLUSH(fl_b), .BUSY(busy_b), .STALL_CNT(st_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected controls {pc, ifid_hold, idex_hold, idex_bubble, exmem_bubble, flush, busy}
  function automatic logic [6:0] model_ctrl(input int k);
    logic lu;
    lu = (MEM_READ_S3 != 3'd0) && (ADDR_S3 != 5'd0) &&
         ((ADDR1 == ADDR_S3) || (ADDR2 == ADDR_S3));
    if (!RESET)          return 7'b0000000;
    if (m_left[k] > 0)   return {4'b1110, (m_left[k] > 1), 2'b01};
    if (BRANCH_TAKEN_S3) return 7'b0001010;
    if (DIV_START_S3)    return 7'b1110100;
    if (lu)              return 7'b1101000;
    return 7'b0000000;
  endfunction

  task automatic model_update();
    logic [6:0] e;
    for (int k = 0; k < 2; k++) begin
      e = model_ctrl(k);
      if (!RESET) begin
        m_left[k]  = 0;
        m_stall[k] = 0;
      end else begin
        if (e[6]) m_stall[k] = (m_stall[k] < cap[k]) ? m_stall[k] + 1 : cap[k];
        if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
        else if (!BRANCH_TAKEN_S3 && DIV_START_S3) m_left[k] = lat[k] - 1;
      end
    end
  endtask

  task automatic step(input logic rst, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [4:0] as3, input logic [2:0] mr, input logic dv,
                      input logic br);
    RESET = rst; ADDR1 = a1; ADDR2 = a2; ADDR_S3 = as3;
    MEM_READ_S3 = mr; DIV_START_S3 = dv; BRANCH_TAKEN_S3 = br;
    #2;
    chk("ctrl_a", 64'({pc_a, ifh_a, idh_a, idb_a, exb_a, fl_a, busy_a}), 64'(model_ctrl(0)));
    chk("ctrl_b", 64'({pc_b, ifh_b, idh_b, idb_b, exb_b, fl_b, busy_b}), 64'(model_ctrl(1)));
    chk("cnt_a", 64'(st_a), 64'(m_stall[0]));
    chk("cnt_b", 64'(st_b), 64'(m_stall[1]));
    chk("excl_a", 64'((idh_a & idb_a) | (fl_a & ifh_a)), 64'd0);
    chk("excl_b", 64'((idh_b & idb_b) | (fl_b & ifh_b)), 64'd0);
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    RESET = 1'b0; ADDR1 = '0; ADDR2 = '0; ADDR_S3 = '0;
    MEM_READ_S3 = '0; DIV_START_S3 = 1'b0; BRANCH_TAKEN_S3 = 1'b0;
    m_left  = '{0, 0};
    m_stall = '{0, 0};
    repeat (2) @(posedge CLK);
    #1;

    // Reset cycle with live inputs still yields zero controls
    step(1'b0, 5'd5, 5'd5, 5'd5, 3'b010, 1'b1, 1'b0);
    chk("rst_cnt_a", 64'(st_a), 64'd0);
    idle(1);

    // Load-use on rs2
    step(1'b1, 5'd7, 5'd5, 5'd5, 3'b010, 1'b0, 1'b0);
    chk("lu_cnt_a", 64'(st_a), 64'd1);
    idle(1);

    // x0 destination never stalls
    step(1'b1, 5'd0, 5'd9, 5'd0, 3'b010, 1'b0, 1'b0);
    chk("x0_cnt_a", 64'(st_a), 64'd1);

    // Branch beats load-use
    step(1'b1, 5'd5, 5'd6, 5'd5, 3'b010, 1'b0, 1'b1);
    chk("br_cnt_a", 64'(st_a), 64'd1);
    chk("br_pc_a", 64'(pc_a), 64'd0);

    // Short divide: holds exactly four cycles on dut_a
    step(1'b0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 1'b0);
    step(1'b1, 5'd1, 5'd2, 5'd3, 3'd0, 1'b1, 1'b0);
    idle(3);
    chk("div_cnt_a", 64'(st_a), 64'd4);
    idle(1);
    chk("div_done_a", 64'(busy_a), 64'd0);
    idle(30);
    chk("div_cnt_b", 64'(st_b), 64'd32);

    // Back-to-back divide on the first free cycle of dut_a
    step(1'b1, 5'd1, 5'd2, 5'd3, 3'd0, 1'b1, 1'b0);
    idle(3);
    step(1'b1, 5'd1, 5'd2, 5'd3, 3'd0, 1'b1, 1'b0);
    idle(3);
    idle(30);

    // Reset two cycles into a long divide aborts it
    step(1'b1, 5'd1, 5'd2, 5'd3, 3'd0, 1'b1, 1'b0);
    idle(1);
    step(1'b0, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 1'b0);
    idle(1);
    chk("rstdiv_busy_b", 64'(busy_b), 64'd0);
    chk("rstdiv_cnt_b", 64'(st_b), 64'd0);

    // Saturation of the narrow counter
    for (int i = 0; i < 20; i++) step(1'b1, 5'd4, 5'd8, 5'd4, 3'b001, 1'b0, 1'b0);
    chk("sat_cnt_a", 64'(st_a), 64'd15);
    chk("sat_cnt_b", 64'(st_b), 64'd20);

    // Randomized traffic with small register range to provoke matches
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) != 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 7)) : 3'd0,
           ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 6) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
